usb_crc5_calc: RTL and testbench

- Byte-parallel USB CRC5 generator/checker for token packets (polynomial x^5+x^2+1).
- Sits in the USB packet datapath beside the protocol engine.
- Folds one 8-bit data byte per enabled clock into a 5-bit running CRC register.
- Exposes the raw register value to the packet encoder/decoder.

---
 rtl/usb_crc_pkg.sv | 24 ++
 rtl/usb_crc5_byte_next.sv | 22 ++
 rtl/usb_crc5_calc.sv | 34 +++
 tb/tb_usb_crc5_calc.sv | 109 ++++++++++
 4 files changed

// File: rtl/usb_crc_pkg.sv
// Shared USB CRC5 constants and the single-bit LFSR step used by the byte-parallel datapath.
package usb_crc_pkg;

  localparam int unsigned     CRC5_W    = 5;
  localparam logic [CRC5_W-1:0] CRC5_POLY = 5'b00101;
  localparam logic [CRC5_W-1:0] CRC5_INIT = 5'b11111;

  function automatic logic [CRC5_W-1:0] crc5_step_bit(
    input logic [CRC5_W-1:0] crc,
    input logic              d
  );
    logic                fb;
    logic [CRC5_W-1:0]   t;
    fb = d ^ crc[CRC5_W-1];
    t  = {crc[CRC5_W-2:0], 1'b0};
    if (fb) begin
      t = t ^ CRC5_POLY;
    end else begin
      t = t;
    end
    return t;
  endfunction

endpackage

// File: rtl/usb_crc5_byte_next.sv
// Combinational fold of one byte into a CRC5 value, bit 0 first (USB wire order).
module usb_crc5_byte_next
  import usb_crc_pkg::*;
(
  input  logic [CRC5_W-1:0] cur,
  input  logic [7:0]        data,
  output logic [CRC5_W-1:0] nxt
);

  logic [CRC5_W-1:0] acc_s;

  // Unrolled chain of eight serial steps
  always_comb begin
    acc_s = cur;
    for (int i = 0; i < 8; i++) begin
      acc_s = crc5_step_bit(acc_s, data[i]);
    end
  end

  assign nxt = acc_s;

endmodule

// File: rtl/usb_crc5_calc.sv
// Byte-parallel USB token CRC5 register; crc_out is the raw register (no inversion/reversal).
module usb_crc5_calc
  import usb_crc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data_in,
  input  logic              crc_en,
  output logic [CRC5_W-1:0] crc_out
);

  logic [CRC5_W-1:0] crc_r;
  logic [CRC5_W-1:0] nxt_s;

  usb_crc5_byte_next u_byte_next (
    .cur  (crc_r),
    .data (data_in),
    .nxt  (nxt_s)
  );

  // CRC state: reset beats enable, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_r <= CRC5_INIT;
    end else if (crc_en) begin
      crc_r <= nxt_s;
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc_out = crc_r;

endmodule

// File: tb/tb_usb_crc5_calc.sv
// Scoreboard bench for usb_crc5_calc: expected values queued at drive time, popped after each edge.
module tb_usb_crc5_calc;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       crc_en;
  logic [4:0] crc_out;

  int checks_cnt;
  int errors_cnt;
  logic [4:0] exp_q[$];
  logic [4:0] model_r;

  usb_crc5_calc dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .crc_en  (crc_en),
    .crc_out (crc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ref_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] t;
    logic       fb;
    t = c;
    for (int i = 0; i < 8; i++) begin
      fb = d[i] ^ t[4];
      t  = {t[3:0], 1'b0};
      if (fb) t = t ^ 5'b00101;
    end
    return t;
  endfunction

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] want);
    checks_cnt++;
    if (got !== want) begin
      errors_cnt++;
      $display("FAIL %s: got %05b expected %05b", tag, got, want);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare just after the edge
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [7:0] d, input logic [4:0] want);
    @(negedge clk);
    rst     = r;
    crc_en  = e;
    data_in = d;
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks_cnt++;
      errors_cnt++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check_eq(tag, crc_out, exp_q.pop_front());
    end
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst = 1'b1;
    crc_en = 1'b0;
    data_in = 8'h00;

    step("reset0", 1'b1, 1'b0, 8'h00, 5'b11111);
    step("reset1", 1'b1, 1'b0, 8'h00, 5'b11111);
    for (int i = 0; i < 5; i++) step("idle_after_reset", 1'b0, 1'b0, 8'($urandom), 5'b11111);

    step("byte00", 1'b0, 1'b1, 8'h00, 5'b01111);

    step("reseed", 1'b1, 1'b0, 8'h00, 5'b11111);
    step("byteAA", 1'b0, 1'b1, 8'hAA, 5'b00011);
    step("b2b_AA2", 1'b0, 1'b1, 8'hAA, 5'b11011);

    step("reseed2", 1'b1, 1'b0, 8'h00, 5'b11111);
    step("gap_AA1", 1'b0, 1'b1, 8'hAA, 5'b00011);
    for (int i = 0; i < 3; i++) step("gap_hold", 1'b0, 1'b0, 8'($urandom), 5'b00011);
    step("gap_AA2", 1'b0, 1'b1, 8'hAA, 5'b11011);

    step("rst_prio", 1'b1, 1'b1, 8'hAA, 5'b11111);
    step("after_rst00", 1'b0, 1'b1, 8'h00, 5'b01111);

    // Random stream against the serial reference model
    step("rand_seed", 1'b1, 1'b0, 8'h00, 5'b11111);
    model_r = 5'b11111;
    for (int i = 0; i < 60; i++) begin
      logic       r;
      logic       e;
      logic [7:0] d;
      r = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      if (r) model_r = 5'b11111;
      else if (e) model_r = ref_byte(model_r, d);
      step("rand_stream", r, e, d, model_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
